// File: rtl/rx_uart.sv
// rx_uart: 8N1 serial receiver with 2-flop input synchronizer.
// Ports: clk, rst (sync, active-high), rx_in (serial line),
//   rx_enable_signal (permit new start detection),
//   rx_data (last good byte), rx_done_signal (good-frame pulse),
//   rx_frame_err (bad-stop pulse), rx_busy (not idle).
module rx_uart #(
    parameter int CLK_FREQ = 100000000,
    parameter int BPS      = 20000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_enable_signal,
    output logic [7:0] rx_data,
    output logic       rx_done_signal,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CPB  = CLK_FREQ / BPS;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;

    assign rx_busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            rx_data        <= '0;
            rx_done_signal <= 1'b0;
            rx_frame_err   <= 1'b0;
            // Line assumed idle so reset never fakes a falling edge
            // while the line is high.
            rx_meta        <= 1'b1;
            rx_sync        <= 1'b1;
            rx_prev        <= 1'b1;
        end else begin
            rx_meta        <= rx_in;
            rx_sync        <= rx_meta;
            rx_prev        <= rx_sync;
            rx_done_signal <= 1'b0;
            rx_frame_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_enable_signal && rx_prev && !rx_sync) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        idx <= '0;
                        // A start bit gone high by mid-bit is a glitch.
                        state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_sync;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            rx_data        <= shreg;
                            rx_done_signal <= 1'b1;
                            state          <= S_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= S_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rx_sync) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: randomized scoreboard bench for rx_uart.
// Frames are queued as expected events; a monitor pops on each pulse.
module tb_rx_uart;

    localparam int CPB  = 5;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done_signal;
    logic       rx_frame_err;
    logic       rx_busy;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         busy_seen = 0;
    logic [7:0] last_good = 8'h00;

    rx_uart dut (
        .clk              (clk),
        .rst              (rst),
        .rx_in            (rx_in),
        .rx_enable_signal (en),
        .rx_data          (rx_data),
        .rx_done_signal   (rx_done_signal),
        .rx_frame_err     (rx_frame_err),
        .rx_busy          (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_busy) busy_seen = 1;
            if (rx_done_signal && rx_frame_err) begin
                check("done_err_overlap", 1, 0);
            end else if (rx_done_signal || rx_frame_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", int'(rx_frame_err), int'(e.err));
                    check("rx_data", int'(rx_data), int'(e.data));
                    if (!e.err) begin
                        check("busy_at_done", int'(rx_busy), 0);
                        if (cyc - e.t0 < LAT - 1 || cyc - e.t0 > LAT + 1)
                            check("latency", cyc - e.t0, LAT);
                        else
                            total++;
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit expect_done,
                        input bit drop_en);
        exp_t e;
        if (expect_done) begin
            e.err = 0;
            e.data = b;
            e.t0 = cyc;
            sb.push_back(e);
            last_good = b;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (drop_en && i == 3) en = 1'b0;
            drive_bit(b[i]);
        end
        drive_bit(1'b1);
        en = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        logic [7:0] b;
        @(negedge clk);
        @(negedge clk);
        check("rst_data", int'(rx_data), 0);
        check("rst_done", int'(rx_done_signal), 0);
        check("rst_err", int'(rx_frame_err), 0);
        check("rst_busy", int'(rx_busy), 0);
        rst = 1'b0;
        idle(4);

        send(8'hA5, 1, 0);
        idle(3);
        check("busy_after_a5", int'(rx_busy), 0);

        send(8'h00, 1, 0);
        send(8'hFF, 1, 0);
        idle(4);

        // One-cycle low glitch must abort silently.
        rx_in = 1'b0;
        @(negedge clk);
        idle(10);
        check("glitch_busy", int'(rx_busy), 0);
        check("glitch_data", int'(rx_data), int'(last_good));

        // Bad stop bit held low, then a good frame.
        e.err = 1;
        e.data = last_good;
        e.t0 = cyc;
        sb.push_back(e);
        b = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rx_in = 1'b0;
        repeat (20) @(negedge clk);
        idle(4);
        send(8'h5A, 1, 0);
        idle(3);

        // Reset during data bit 4 of 0xF0 (line high at that point).
        b = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("midrst_data", int'(rx_data), 0);
        check("midrst_busy", int'(rx_busy), 0);
        check("midrst_done", int'(rx_done_signal), 0);
        check("midrst_err", int'(rx_frame_err), 0);
        idle(4 * CPB + 4);
        send(8'h81, 1, 0);
        idle(3);

        // Disabled for a whole frame: nothing happens.
        en = 1'b0;
        busy_seen = 0;
        send(8'h6E, 0, 0);
        idle(3);
        check("dis_busy_seen", int'(busy_seen), 0);
        check("dis_data", int'(rx_data), int'(last_good));
        en = 1'b1;

        // Enable dropped mid-frame still completes.
        send(8'hC3, 1, 1);
        idle(3);

        for (int k = 0; k < 12; k++) begin
            send(8'($urandom_range(0, 255)), 1, 0);
            idle($urandom_range(0, 6));
        end

        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("final_data", int'(rx_data), int'(last_good));
        check("final_busy", int'(rx_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_uart.md
RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BPS, default 20000000, line bit rate; CLKS_PER_BIT = CLK_FREQ/BPS (default 5); HALF = CLKS_PER_BIT/2, integer floor (default 2).
REQ-003 clk  input  1  system clock, all logic on rising edge; one clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rx_in  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-006 rx_enable_signal  input  1  high permits detection of new start bits.
REQ-007 rx_data  output  8  last correctly received byte, held until the next good frame.
REQ-008 rx_done_signal  output  1  one-cycle pulse; rx_data is valid in the same cycle.
REQ-009 rx_frame_err  output  1  one-cycle pulse; stop bit was sampled low.
REQ-010 rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer (rx_sync); a third register (rx_prev) SHALL hold the previous rx_sync value for edge detection.
REQ-012 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE; a bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) SHALL be used.
REQ-013 IDLE: when rx_enable_signal=1, rx_prev=1 and rx_sync=0, the block SHALL go to START with counter=0; otherwise it SHALL stay in IDLE.
REQ-014 START: the counter SHALL increment each cycle; at counter=HALF-1, rx_sync=0 SHALL go to DATA (counter=0, index=0); rx_sync=1 SHALL count as a glitch and go to IDLE with no output pulse.
REQ-015 DATA: at counter=CLKS_PER_BIT-1, rx_sync SHALL be shifted into bit[index] (LSB first) and the counter SHALL reset to 0; after index 7 is sampled, the block SHALL go to STOP.
REQ-016 STOP: at counter=CLKS_PER_BIT-1, rx_sync=1 SHALL load rx_data from the shift register, pulse rx_done_signal for exactly one cycle (registered, next cycle), and go to IDLE.
REQ-017 STOP: at counter=CLKS_PER_BIT-1, rx_sync=0 SHALL pulse rx_frame_err for one cycle, leave rx_data unchanged, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL go to IDLE on the first cycle with rx_sync=1; a new start bit SHALL then need a fresh 1->0 edge.
REQ-019 Deasserting rx_enable_signal mid-frame SHALL NOT abort the frame; it SHALL only block the next start detection.
REQ-020 Back-to-back frames SHALL be accepted: a start edge arriving in the cycle after return to IDLE SHALL be detected.
REQ-021 rx_done_signal and rx_frame_err SHALL never be high in the same cycle; each SHALL pulse at most once per frame.
REQ-022 Latency from the rx_in start-bit falling edge to the rx_done_signal pulse SHALL be fixed at synchronizer (2) + edge detect (1) + HALF + 9*CLKS_PER_BIT + 1 cycles, ±1 for input phase.
REQ-023 The design SHALL require CLKS_PER_BIT >= 4; smaller values are unsupported.

Reset
REQ-024 While rst=1: state=IDLE, counter=0, index=0, shift register=0x00, rx_data=0x00, rx_done_signal=0, rx_frame_err=0, rx_busy=0; synchronizer and rx_prev flops=1 (line idle).
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, the block SHALL wait for a new 1->0 edge.

Verification
REQ-026 Enable=1, send 0xA5 at 5 clk/bit -> exactly one rx_done_signal pulse, rx_data=0xA5, rx_frame_err stays 0, rx_busy low after the pulse.
REQ-027 Send 0x00 then 0xFF with zero idle gap between the stop bit and the next start bit -> two done pulses; rx_data=0x00, then 0xFF.
REQ-028 Drive rx_in low for 1 cycle only -> START aborts to IDLE; no done or err pulse; rx_data unchanged.
REQ-029 Send 0x3C with stop bit held low for 20 cycles, then high -> one rx_frame_err pulse; rx_data keeps its prior value; the next good frame 0x5A is received correctly.
REQ-030 Assert rst for 1 cycle during data bit 4 of a frame -> all outputs return to reset values; the rest of that frame is not reported; the next full frame 0x81 is received.
REQ-031 rx_enable_signal=0 during a whole frame -> no pulses, rx_busy=0; enable dropped mid-frame -> that frame still completes with a done pulse.
